// File: rtl/uart_reg_pkg.sv
// Shared constants and types for the UART register block: register addresses,
// CTRL/STATUS bit positions and the line-control struct.
package uart_reg_pkg;

  localparam int ADDR_W = 13;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 13'h000;
  localparam logic [ADDR_W-1:0] ADDR_BAUD_DIV = 13'h004;
  localparam logic [ADDR_W-1:0] ADDR_TX_DATA  = 13'h008;
  localparam logic [ADDR_W-1:0] ADDR_RX_DATA  = 13'h00C;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 13'h010;

  localparam int CTRL_IE_RX = 5;
  localparam int CTRL_IE_TX = 6;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_PERR     = 6;

  // Packed so that ctrl_o[0] is tx_en and ctrl_o[4] is stop2.
  typedef struct packed {
    logic stop2;
    logic par_odd;
    logic par_en;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

  // A divider of zero would stall the baud generator, so it is stored as 1.
  function automatic logic [15:0] baud_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/uart_reg_if.sv
// Register access bus between the APB slave (master side) and the UART
// register block (slave side).
interface uart_reg_if;
  import uart_reg_pkg::*;

  logic [ADDR_W-1:0] reg_addr_i;
  logic [31:0]       reg_wdata_i;
  logic [3:0]        reg_strb_i;
  logic              reg_we_i;
  logic [31:0]       reg_rdata_o;

  modport master (
    output reg_addr_i, reg_wdata_i, reg_strb_i, reg_we_i,
    input  reg_rdata_o
  );

  modport slave (
    input  reg_addr_i, reg_wdata_i, reg_strb_i, reg_we_i,
    output reg_rdata_o
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with head-of-queue output. Push into a full FIFO succeeds
// only when a pop happens in the same cycle; DEPTH=1 degenerates to a holding register.
module uart_sync_fifo import uart_reg_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic do_push;
  logic do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  generate
    if (DEPTH == 1) begin : g_hold
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          if (do_push) begin
            data_q  <= wdata;
            valid_q <= 1'b1;
          end else if (do_pop) begin
            valid_q <= 1'b0;
          end
        end
      end

      assign full  = valid_q;
      assign empty = ~valid_q;
      assign head  = data_q;
    end else begin : g_ring
      localparam int AW = $clog2(DEPTH);
      localparam int CW = AW + 1;

      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [CW-1:0]    count;

      // Power-of-two depth: pointers wrap by natural overflow.
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
          if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
          end
          if (do_pop) rd_ptr <= rd_ptr + AW'(1);
          case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end

      assign full  = (count == CW'(DEPTH));
      assign empty = (count == '0);
      assign head  = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: rtl/uart_reg_block.sv
// UART register block: CTRL/BAUD_DIV/TX_DATA/RX_DATA/STATUS map, TX/RX buffers,
// sticky error flags and registered interrupt. UART_REG_FIFO_EN selects FIFO_DEPTH-deep buffers.
module uart_reg_block import uart_reg_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  uart_reg_if.slave        reg_bus,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_perr_i,
  output logic [4:0]       ctrl_o,
  output logic [15:0]      baud_div_o,
  output logic             irq_o
);

`ifdef UART_REG_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH only sizes the FIFO build.
  localparam int BUF_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

  ctrl_t       ctrl_q;
  logic        ie_rx_q;
  logic        ie_tx_q;
  logic [15:0] baud_q;
  logic        tx_ovf_q;
  logic        rx_ovr_q;
  logic        perr_q;
  logic        irq_q;

  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;

  logic        sel_ctrl, sel_baud, sel_tx, sel_rx, sel_status;
  logic        wr_lane0;
  logic [15:0] baud_merged;
  logic        tx_push, tx_pop, rx_push, rx_pop, w1c;
  logic        tx_ovf_set, rx_ovr_set, perr_set;
  logic [31:0] status_rd;
  logic        unused_bits;

  assign sel_ctrl   = (reg_bus.reg_addr_i == ADDR_CTRL);
  assign sel_baud   = (reg_bus.reg_addr_i == ADDR_BAUD_DIV);
  assign sel_tx     = (reg_bus.reg_addr_i == ADDR_TX_DATA);
  assign sel_rx     = (reg_bus.reg_addr_i == ADDR_RX_DATA);
  assign sel_status = (reg_bus.reg_addr_i == ADDR_STATUS);
  assign wr_lane0   = reg_bus.reg_we_i & reg_bus.reg_strb_i[0];

  assign baud_merged = {reg_bus.reg_strb_i[1] ? reg_bus.reg_wdata_i[15:8] : baud_q[15:8],
                        reg_bus.reg_strb_i[0] ? reg_bus.reg_wdata_i[7:0]  : baud_q[7:0]};

  assign tx_push = wr_lane0 & sel_tx;
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & ctrl_q.rx_en;
  assign rx_pop  = reg_bus.reg_we_i & sel_rx;
  assign w1c     = wr_lane0 & sel_status;

  // TX never accepts into a full buffer, even alongside a pop; RX does.
  assign tx_ovf_set = tx_push & tx_full;
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
  assign perr_set   = rx_push & rx_perr_i;

  uart_sync_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(8)) u_tx_fifo (
    .pclk    (pclk),
    .presetn (presetn),
    .push    (tx_push & ~tx_full),
    .pop     (tx_pop),
    .wdata   (reg_bus.reg_wdata_i[7:0]),
    .full    (tx_full),
    .empty   (tx_empty),
    .head    (tx_head)
  );

  uart_sync_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(8)) u_rx_fifo (
    .pclk    (pclk),
    .presetn (presetn),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_data_i),
    .full    (rx_full),
    .empty   (rx_empty),
    .head    (rx_head)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_q   <= '0;
      ie_rx_q  <= 1'b0;
      ie_tx_q  <= 1'b0;
      baud_q   <= 16'd1;
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      perr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_lane0 && sel_ctrl) begin
        ctrl_q  <= ctrl_t'(reg_bus.reg_wdata_i[4:0]);
        ie_rx_q <= reg_bus.reg_wdata_i[CTRL_IE_RX];
        ie_tx_q <= reg_bus.reg_wdata_i[CTRL_IE_TX];
      end
      if (reg_bus.reg_we_i && sel_baud && (|reg_bus.reg_strb_i[1:0]))
        baud_q <= baud_sanitize(baud_merged);
      // Set wins over a same-cycle clear.
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~(w1c & reg_bus.reg_wdata_i[ST_TX_OVF]));
      rx_ovr_q <= rx_ovr_set | (rx_ovr_q & ~(w1c & reg_bus.reg_wdata_i[ST_RX_OVR]));
      perr_q   <= perr_set   | (perr_q   & ~(w1c & reg_bus.reg_wdata_i[ST_PERR]));
      irq_q    <= (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_empty) | tx_ovf_q | rx_ovr_q | perr_q;
    end
  end

  always_comb begin
    status_rd              = '0;
    status_rd[ST_TX_FULL]  = tx_full;
    status_rd[ST_TX_EMPTY] = tx_empty;
    status_rd[ST_RX_EMPTY] = rx_empty;
    status_rd[ST_RX_FULL]  = rx_full;
    status_rd[ST_TX_OVF]   = tx_ovf_q;
    status_rd[ST_RX_OVR]   = rx_ovr_q;
    status_rd[ST_PERR]     = perr_q;
  end

  always_comb begin
    reg_bus.reg_rdata_o = '0;
    if (sel_ctrl)   reg_bus.reg_rdata_o = {25'b0, ie_tx_q, ie_rx_q, ctrl_q};
    if (sel_baud)   reg_bus.reg_rdata_o = {16'b0, baud_q};
    if (sel_rx)     reg_bus.reg_rdata_o = rx_empty ? 32'b0 : {24'b0, rx_head};
    if (sel_status) reg_bus.reg_rdata_o = status_rd;
  end

  assign tx_valid_o = ~tx_empty & ctrl_q.tx_en;
  assign tx_data_o  = tx_head;
  assign ctrl_o     = ctrl_q;
  assign baud_div_o = baud_q;
  assign irq_o      = irq_q;

  assign unused_bits = ^{reg_bus.reg_wdata_i[31:16], reg_bus.reg_strb_i[3:2]};

endmodule

// File: tb/tb_uart_reg_block.sv
// Testbench for uart_reg_block: directed register-map scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_uart_reg_block;

`ifdef UART_REG_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_perr_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic [4:0]  ctrl_o;
  logic [15:0] baud_div_o;
  logic        irq_o;

  uart_reg_if bus();

  uart_reg_block #(.FIFO_DEPTH(4)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .reg_bus    (bus),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_perr_i  (rx_perr_i),
    .ctrl_o     (ctrl_o),
    .baud_div_o (baud_div_o),
    .irq_o      (irq_o)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [6:0]  m_ctrl;
  logic [15:0] m_baud;
  logic        m_tx_ovf, m_rx_ovr, m_perr, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [12:0] a);
    case (a)
      13'h000: return {25'b0, m_ctrl};
      13'h004: return {16'b0, m_baud};
      13'h00C: return (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'b0;
      13'h010: return {25'b0, m_perr, m_rx_ovr, m_tx_ovf,
                       rxq.size() == D, rxq.size() == 0, txq.size() == 0, txq.size() == D};
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_reset();
    txq.delete();
    rxq.delete();
    m_ctrl = '0;
    m_baud = 16'd1;
    m_tx_ovf = 1'b0;
    m_rx_ovr = 1'b0;
    m_perr = 1'b0;
    m_irq = 1'b0;
  endtask

  // One clock of the model, from the inputs currently driven.
  task automatic m_step();
    logic we;
    logic [12:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    logic [15:0] nb;
    bit tx_pop, rx_pop, tx_push, rx_push;
    int tx_n, rx_n;
    we = bus.reg_we_i;
    a  = bus.reg_addr_i;
    wd = bus.reg_wdata_i;
    st = bus.reg_strb_i;
    tx_n = txq.size();
    rx_n = rxq.size();
    m_irq = (m_ctrl[5] && rx_n > 0) || (m_ctrl[6] && tx_n == 0) || m_tx_ovf || m_rx_ovr || m_perr;
    tx_pop  = m_ctrl[0] && tx_n > 0 && tx_ready_i;
    tx_push = we && a == 13'h008 && st[0];
    rx_pop  = we && a == 13'h00C && rx_n > 0;
    rx_push = rx_valid_i && m_ctrl[1];
    if (we && a == 13'h010 && st[0]) begin
      if (wd[4]) m_tx_ovf = 1'b0;
      if (wd[5]) m_rx_ovr = 1'b0;
      if (wd[6]) m_perr = 1'b0;
    end
    if (tx_pop) void'(txq.pop_front());
    if (tx_push) begin
      if (tx_n == D) m_tx_ovf = 1'b1;
      else txq.push_back(wd[7:0]);
    end
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) begin
      if (rx_n == D && !rx_pop) m_rx_ovr = 1'b1;
      else rxq.push_back(rx_data_i);
      if (rx_perr_i) m_perr = 1'b1;
    end
    if (we && a == 13'h000 && st[0]) m_ctrl = wd[6:0];
    if (we && a == 13'h004 && st[1:0] != 2'b00) begin
      nb = m_baud;
      if (st[0]) nb[7:0] = wd[7:0];
      if (st[1]) nb[15:8] = wd[15:8];
      m_baud = (nb == 16'd0) ? 16'd1 : nb;
    end
  endtask

  task automatic check_outs();
    bit txv;
    txv = m_ctrl[0] && txq.size() != 0;
    chk("ctrl_o", {27'b0, ctrl_o}, {27'b0, m_ctrl[4:0]});
    chk("baud_div_o", {16'b0, baud_div_o}, {16'b0, m_baud});
    chk("tx_valid_o", {31'b0, tx_valid_o}, {31'b0, txv});
    if (txv) chk("tx_data_o", {24'b0, tx_data_o}, {24'b0, txq[0]});
    chk("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
  endtask

  task automatic tick();
    m_step();
    @(posedge pclk);
    #1;
    check_outs();
  endtask

  task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.reg_we_i = 1'b1;
    bus.reg_addr_i = a;
    bus.reg_wdata_i = d;
    bus.reg_strb_i = s;
    tick();
    bus.reg_we_i = 1'b0;
    bus.reg_strb_i = 4'h0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic perr);
    rx_valid_i = 1'b1;
    rx_data_i = d;
    rx_perr_i = perr;
    tick();
    rx_valid_i = 1'b0;
    rx_perr_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [12:0] a);
    bus.reg_addr_i = a;
    #1;
    chk(tag, bus.reg_rdata_o, m_read(a));
  endtask

  task automatic rd_exp(input string tag, input logic [12:0] a, input logic [31:0] exp);
    bus.reg_addr_i = a;
    #1;
    chk(tag, bus.reg_rdata_o, exp);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    m_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk);
    #1;
    check_outs();
  endtask

  initial begin
    bus.reg_we_i = 1'b0;
    bus.reg_addr_i = '0;
    bus.reg_wdata_i = '0;
    bus.reg_strb_i = '0;
    do_reset();

    // Reset values
    rd_exp("rst_ctrl", 13'h000, 32'h0);
    rd_exp("rst_baud", 13'h004, 32'h1);
    rd_exp("rst_txdata", 13'h008, 32'h0);
    rd_exp("rst_rxdata", 13'h00C, 32'h0);
    rd_exp("rst_status", 13'h010, 32'h6);
    rd_exp("unmapped", 13'h014, 32'h0);

    // Baud divider byte lanes and zero handling
    wr(13'h004, 32'h0000_0145, 4'h3);
    chk("baud_145", {16'b0, baud_div_o}, 32'h145);
    wr(13'h004, 32'h0000_0022, 4'h1);
    chk("baud_122", {16'b0, baud_div_o}, 32'h122);
    wr(13'h004, 32'h0000_FFFF, 4'h0);
    rd_exp("baud_nostrb", 13'h004, 32'h122);
    wr(13'h004, 32'h0, 4'h3);
    rd_exp("baud_zero", 13'h004, 32'h1);
    wr(13'h014, 32'hFFFF_FFFF, 4'hF);
    rd_exp("unmapped_wr", 13'h014, 32'h0);

    // TX fill past full, then drain in order
    wr(13'h000, 32'h1, 4'h1);
    tx_ready_i = 1'b0;
    for (int i = 0; i <= D; i++) wr(13'h008, 32'hA1 + i, 4'h1);
    rd_exp("tx_full_ovf", 13'h010, 32'h15);
    tx_ready_i = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("tx_order", {24'b0, tx_data_o}, 32'hA1 + i);
      tick();
    end
    tx_ready_i = 1'b0;
    chk("tx_drained", {31'b0, tx_valid_o}, 32'h0);
    rd_exp("tx_empty", 13'h010, 32'h16);
    wr(13'h010, 32'h10, 4'h1);
    rd_exp("tx_ovf_clr", 13'h010, 32'h6);

    // RX fill past full, then pop
    wr(13'h000, 32'h3, 4'h1);
    for (int i = 0; i <= D; i++) rx_byte(8'h10 + 8'(i), 1'b0);
    rd_exp("rx_head", 13'h00C, 32'h10);
    rd_exp("rx_full_ovr", 13'h010, 32'h2A);
    for (int i = 0; i < D; i++) begin
      wr(13'h00C, 32'h0, 4'h0);
      if (i < D - 1) rd_exp("rx_pop_seq", 13'h00C, 32'h11 + i);
    end
    rd_exp("rx_empty", 13'h010, 32'h26);
    wr(13'h00C, 32'h0, 4'h1);
    rd_exp("rx_pop_empty", 13'h010, 32'h26);
    wr(13'h010, 32'h70, 4'h1);
    rd_exp("rx_ovr_clr", 13'h010, 32'h6);

    // RX full with simultaneous push and pop: no overrun
    for (int i = 0; i < D; i++) rx_byte(8'h30 + 8'(i), 1'b0);
    rx_valid_i = 1'b1;
    rx_data_i = 8'h55;
    wr(13'h00C, 32'h0, 4'h0);
    rx_valid_i = 1'b0;
    rd_exp("simul_no_ovr", 13'h010, 32'h0A);
    rd_chk("simul_head", 13'h00C);
    for (int i = 0; i < D; i++) wr(13'h00C, 32'h0, 4'h1);
    rd_exp("simul_drained", 13'h010, 32'h6);

    // Parity error raises irq one cycle later; clear and pop drops it
    wr(13'h000, 32'h23, 4'h1);
    rx_byte(8'h77, 1'b1);
    chk("irq_not_yet", {31'b0, irq_o}, 32'h0);
    tick();
    chk("irq_perr", {31'b0, irq_o}, 32'h1);
    rd_chk("perr_status", 13'h010);
    wr(13'h010, 32'h40, 4'h1);
    wr(13'h00C, 32'h0, 4'h1);
    tick();
    chk("irq_cleared", {31'b0, irq_o}, 32'h0);

    // Reset with bytes queued discards them
    wr(13'h000, 32'h1, 4'h1);
    wr(13'h008, 32'hEE, 4'h1);
    wr(13'h008, 32'hEF, 4'h1);
    do_reset();
    chk("rst_mid_txv", {31'b0, tx_valid_o}, 32'h0);
    rd_exp("rst_mid_status", 13'h010, 32'h6);
    tx_ready_i = 1'b1;
    wr(13'h000, 32'h1, 4'h1);
    tick();
    chk("rst_no_stale", {31'b0, tx_valid_o}, 32'h0);
    tx_ready_i = 1'b0;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      bus.reg_we_i = ($urandom_range(0, 2) == 0);
      bus.reg_addr_i = 13'($urandom_range(0, 5) * 4);
      bus.reg_wdata_i = $urandom;
      bus.reg_strb_i = 4'($urandom_range(0, 15));
      tx_ready_i = $urandom_range(0, 1) == 1;
      rx_valid_i = $urandom_range(0, 1) == 1;
      rx_data_i = 8'($urandom);
      rx_perr_i = ($urandom_range(0, 7) == 0);
      tick();
      bus.reg_we_i = 1'b0;
      rx_valid_i = 1'b0;
      rd_chk("rand_read", 13'($urandom_range(0, 5) * 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
